// File: rtl/nibble_serial_adder.sv
// Sequential wide adder: adds two 4*NIBBLES-bit operands one nibble per clock through a
// single four_bit_adder, least-significant nibble first, with the inter-nibble carry in a
// register. start/busy/done handshake; outputs are all registered.

module four_bit_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};

endmodule

module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [4*NIBBLES-1:0]   a_i,
    input  logic [4*NIBBLES-1:0]   b_i,
    input  logic                   cin_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [4*NIBBLES-1:0]   sum_o,
    output logic                   cout_o
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    part_q, part_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [W-1:0]    a_shift;
    logic [W-1:0]    b_shift;
    logic [3:0]      fa_sum;
    logic            fa_cout;

    // Bring the current nibble down to bit 0 instead of a variable part-select.
    assign a_shift = a_q >> {idx_q, 2'b00};
    assign b_shift = b_q >> {idx_q, 2'b00};

    four_bit_adder u_four_bit_adder (
        .a_i    (a_shift[3:0]),
        .b_i    (b_shift[3:0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle, StDone: begin
                // The DONE cycle accepts a new start too, giving back-to-back issue.
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = cin_i;
                    idx_d   = '0;
                    state_d = StAdd;
                end else begin
                    state_d = StIdle;
                end
            end
            StAdd: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IdxW'(i)) begin
                        part_d[4*i +: 4] = fa_sum;
                    end
                end
                carry_d = fa_cout;
                if (idx_q == LastIdx) begin
                    sum_d   = part_d;
                    cout_d  = fa_cout;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StAdd);
        done_d = (state_d == StDone);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule
